// File: rtl/frag_fb_writer_pkg.sv
// Shared framebuffer definitions: geometry defaults, field widths, fragment record, pixel packing.
package frag_fb_writer_pkg;

  localparam int FB_WIDTH_DEF   = 320;
  localparam int FB_HEIGHT_DEF  = 240;
  localparam int FB_ADDR_WIDTH  = 18;
  localparam int COLOR_WIDTH    = 12;
  localparam int COORD_WIDTH    = 10;
  localparam int GPU_DATA_WIDTH = 16;
  localparam int FRAG_WIDTH     = 2 * COORD_WIDTH + COLOR_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COLOR_WIDTH-1:0] color;
  } frag_t;

  function automatic logic [GPU_DATA_WIDTH-1:0] fb_pixel(input logic [COLOR_WIDTH-1:0] color);
    return {4'b0, color};
  endfunction

endpackage

// File: rtl/frag_fb_writer_fifo.sv
// Fragment FIFO: array storage plus a registered head word; o_empty reflects the head register.
module frag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_nz
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      r_mem_count;
  logic             r_out_valid;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [AW:0]      w_count_next;

  assign w_push       = i_push & ~r_full;
  assign w_pop        = i_pop & r_out_valid;
  // Head register refills whenever it is empty or being popped and the array holds data.
  assign w_load       = (~r_out_valid | w_pop) & (r_mem_count != '0);
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (w_load) r_dout <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_mem_count <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_count <= r_mem_count + (AW+1)'(w_push) - (AW+1)'(w_load);
      if (w_load)     r_out_valid <= 1'b1;
      else if (w_pop) r_out_valid <= 1'b0;
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
    end
  end

  assign o_dout  = r_dout;
  assign o_full  = r_full;
  assign o_empty = ~r_out_valid;
  assign o_nz    = (r_count != '0);

endmodule

// File: rtl/frag_fb_writer.sv
// Drains rasterizer fragments into the framebuffer during blanking; also runs full-screen clears.
module frag_fb_writer
  import frag_fb_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FB_WIDTH   = FB_WIDTH_DEF,
  parameter int FB_HEIGHT  = FB_HEIGHT_DEF
) (
  input  logic                      I_CLK,
  input  logic                      I_RST,
  input  logic                      I_FRAG_VALID,
  output logic                      O_FRAG_READY,
  input  logic [COORD_WIDTH-1:0]    I_FRAG_X,
  input  logic [COORD_WIDTH-1:0]    I_FRAG_Y,
  input  logic [COLOR_WIDTH-1:0]    I_FRAG_COLOR,
  input  logic                      I_CLEAR,
  input  logic [COLOR_WIDTH-1:0]    I_CLEAR_COLOR,
  input  logic                      I_VIDEO_ON,
  output logic [FB_ADDR_WIDTH-1:0]  O_GPU_ADDR,
  output logic [GPU_DATA_WIDTH-1:0] O_GPU_DATA,
  output logic                      O_GPU_WRITE,
  output logic                      O_GPU_READ,
  output logic                      O_BUSY,
  output logic [15:0]               O_DROP_CNT
);

  localparam logic [COORD_WIDTH-1:0]   X_LIM     = COORD_WIDTH'(FB_WIDTH);
  localparam logic [COORD_WIDTH-1:0]   Y_LIM     = COORD_WIDTH'(FB_HEIGHT);
  localparam logic [FB_ADDR_WIDTH-1:0] ROW_WORDS = FB_ADDR_WIDTH'(FB_WIDTH);
  localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);

  wr_state_t                 r_state;
  wr_state_t                 w_state_next;
  logic                      r_stg_valid;
  logic                      r_stg_clr;
  logic [FB_ADDR_WIDTH-1:0]  r_stg_addr;
  logic [GPU_DATA_WIDTH-1:0] r_stg_data;
  logic [FB_ADDR_WIDTH-1:0]  r_caddr;
  logic [COLOR_WIDTH-1:0]    r_clr_color;
  logic                      r_clr_done;
  logic [15:0]               r_drop_cnt;

  logic                      w_accept;
  logic                      w_in_range;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic                      w_fifo_nz;
  logic [FRAG_WIDTH-1:0]     w_fifo_dout;
  frag_t                     w_head;
  frag_t                     w_in_frag;
  logic [FB_ADDR_WIDTH-1:0]  w_frag_addr;
  logic                      w_consume;
  logic                      w_stage_ready;
  logic                      w_load_frag;
  logic                      w_load_clr;

  assign w_accept   = I_FRAG_VALID & O_FRAG_READY;
  assign w_in_range = (I_FRAG_X < X_LIM) && (I_FRAG_Y < Y_LIM);
  assign w_push     = w_accept & w_in_range;
  assign w_in_frag  = '{x: I_FRAG_X, y: I_FRAG_Y, color: I_FRAG_COLOR};

  frag_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAG_WIDTH)
  ) u_fifo (
    .i_clk   (I_CLK),
    .i_rst   (I_RST),
    .i_push  (w_push),
    .i_din   (w_in_frag),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_nz    (w_fifo_nz)
  );

  assign w_head      = frag_t'(w_fifo_dout);
  assign w_frag_addr = {8'b0, w_head.y} * ROW_WORDS + {8'b0, w_head.x};

  // The stage can take a new word when empty or when its current word leaves this edge.
  assign w_consume     = r_stg_valid & ~I_VIDEO_ON;
  assign w_stage_ready = ~r_stg_valid | w_consume;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_frag  = 1'b0;
    w_load_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (I_CLEAR) begin
          w_state_next = ST_CLEAR;
        end else if (~w_fifo_empty && w_stage_ready) begin
          w_pop       = 1'b1;
          w_load_frag = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (w_stage_ready && ~r_clr_done) w_load_clr = 1'b1;
        if (w_consume && r_stg_clr && (r_stg_addr == LAST_ADDR)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_state     <= ST_IDLE;
      r_stg_valid <= 1'b0;
      r_stg_clr   <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
      r_caddr     <= '0;
      r_clr_color <= '0;
      r_clr_done  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && I_CLEAR) begin
        r_caddr     <= '0;
        r_clr_color <= I_CLEAR_COLOR;
        r_clr_done  <= 1'b0;
      end
      if (w_load_frag) begin
        r_stg_valid <= 1'b1;
        r_stg_clr   <= 1'b0;
        r_stg_addr  <= w_frag_addr;
        r_stg_data  <= fb_pixel(w_head.color);
      end else if (w_load_clr) begin
        r_stg_valid <= 1'b1;
        r_stg_clr   <= 1'b1;
        r_stg_addr  <= r_caddr;
        r_stg_data  <= fb_pixel(r_clr_color);
        r_caddr     <= r_caddr + 1'b1;
        r_clr_done  <= (r_caddr == LAST_ADDR);
      end else if (w_consume) begin
        r_stg_valid <= 1'b0;
      end
      if (w_accept && ~w_in_range && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign O_FRAG_READY = ~w_fifo_full;
  assign O_GPU_WRITE  = w_consume;
  assign O_GPU_ADDR   = r_stg_addr;
  assign O_GPU_DATA   = r_stg_data;
  assign O_GPU_READ   = 1'b0;
  assign O_BUSY       = (r_state == ST_CLEAR) | w_fifo_nz | r_stg_valid;
  assign O_DROP_CNT   = r_drop_cnt;

endmodule

// File: tb/tb_frag_fb_writer.sv
// Directed bench for frag_fb_writer: reset, single write, back-pressure, drops, clears, abort.
module tb_frag_fb_writer;

  localparam int W    = 320;
  localparam int H    = 240;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        frag_valid;
  logic        frag_ready;
  logic [9:0]  frag_x;
  logic [9:0]  frag_y;
  logic [11:0] frag_color;
  logic        clear;
  logic [11:0] clear_color;
  logic        video_on;
  logic [17:0] gpu_addr;
  logic [15:0] gpu_data;
  logic        gpu_write;
  logic        gpu_read;
  logic        busy;
  logic [15:0] drop_cnt;

  frag_fb_writer dut (
    .I_CLK         (clk),
    .I_RST         (rst),
    .I_FRAG_VALID  (frag_valid),
    .O_FRAG_READY  (frag_ready),
    .I_FRAG_X      (frag_x),
    .I_FRAG_Y      (frag_y),
    .I_FRAG_COLOR  (frag_color),
    .I_CLEAR       (clear),
    .I_CLEAR_COLOR (clear_color),
    .I_VIDEO_ON    (video_on),
    .O_GPU_ADDR    (gpu_addr),
    .O_GPU_DATA    (gpu_data),
    .O_GPU_WRITE   (gpu_write),
    .O_GPU_READ    (gpu_read),
    .O_BUSY        (busy),
    .O_DROP_CNT    (drop_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int wr_total    = 0;
  int video_viol  = 0;

  // Counts writes the DUT presents for the coming edge, and any presented while video is on.
  always begin
    @(negedge clk);
    #2;
    if (!rst && gpu_write) begin
      wr_total++;
      if (video_on) video_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [9:0] px, input logic [9:0] py, input logic [11:0] pc,
                      output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    frag_valid = 1'b1;
    frag_x     = px;
    frag_y     = py;
    frag_color = pc;
    #1;
    while (!frag_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = frag_ready;
    @(negedge clk);
    frag_valid = 1'b0;
  endtask

  bit          ok;
  int          acc;
  int          wr0;
  int          nwr;
  int          seq_err;
  int          first_c;
  int          last_c;
  int          exp_n;
  bit          got;
  logic [17:0] exp_addr;
  logic [15:0] exp_data;
  logic [17:0] seen_addr;
  logic [15:0] seen_data;

  initial begin
    rst = 1'b1; frag_valid = 1'b0; frag_x = '0; frag_y = '0; frag_color = '0;
    clear = 1'b0; clear_color = '0; video_on = 1'b0;

    // 1: random inputs under reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      frag_valid  = 1'($urandom_range(0, 1));
      frag_x      = 10'($urandom);
      frag_y      = 10'($urandom);
      frag_color  = 12'($urandom);
      clear       = 1'($urandom_range(0, 1));
      clear_color = 12'($urandom);
      video_on    = 1'($urandom_range(0, 1));
      #1;
      chk("rst_write", 32'(gpu_write), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    chk("rst_addr", 32'(gpu_addr), 0);
    chk("rst_data", 32'(gpu_data), 0);
    @(negedge clk);
    rst = 1'b0; frag_valid = 1'b0; clear = 1'b0; video_on = 1'b0;
    @(negedge clk); #1;
    chk("ready_post_rst", 32'(frag_ready), 1);
    chk("read_tied", 32'(gpu_read), 0);

    // 2: single fragment, 2-cycle latency
    @(negedge clk);
    frag_valid = 1'b1; frag_x = 10'd5; frag_y = 10'd2; frag_color = 12'hF0A;
    #1;
    chk("t2_ready", 32'(frag_ready), 1);
    @(negedge clk); frag_valid = 1'b0; #1;
    chk("t2_wr_e0", 32'(gpu_write), 0);
    @(negedge clk); #1;
    chk("t2_wr_e1", 32'(gpu_write), 0);
    chk("t2_busy", 32'(busy), 1);
    @(negedge clk); #1;
    chk("t2_wr_e2", 32'(gpu_write), 1);
    chk("t2_addr", 32'(gpu_addr), 645);
    chk("t2_data", 32'(gpu_data), 32'h0F0A);
    @(negedge clk); #1;
    chk("t2_wr_after", 32'(gpu_write), 0);
    chk("t2_idle", 32'(busy), 0);

    // 3: video on, FIFO fills, then drains in order at one word per cycle
    @(negedge clk); video_on = 1'b1;
    wr0 = wr_total;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      push(10'(i), 10'(i + 1), 12'(i * 273), ok);
      if (ok) acc++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("t3_accepted", 32'(acc), 17);
    chk("t3_ready_full", 32'(frag_ready), 0);
    chk("t3_no_writes", 32'(wr_total - wr0), 0);
    chk("t3_busy", 32'(busy), 1);
    nwr = 0; seq_err = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      video_on = 1'b0;
      #1;
      if (gpu_write) begin
        exp_addr = 18'((nwr + 1) * W + nwr);
        exp_data = {4'b0, 12'(nwr * 273)};
        if (gpu_addr !== exp_addr || gpu_data !== exp_data) seq_err++;
        if (first_c < 0) first_c = c;
        last_c = c;
        nwr++;
      end
    end
    chk("t3_drain_cnt", 32'(nwr), 17);
    chk("t3_order_err", 32'(seq_err), 0);
    chk("t3_back2back", 32'(last_c - first_c), 16);
    chk("t3_ready_back", 32'(frag_ready), 1);

    // 4: out-of-range fragments are accepted and counted, not written
    wr0 = wr_total;
    push(10'd320, 10'd0, 12'h111, ok);
    chk("t4_acc_x", 32'(ok), 1);
    push(10'd0, 10'd240, 12'h222, ok);
    chk("t4_acc_y", 32'(ok), 1);
    repeat (6) @(negedge clk);
    #1;
    chk("t4_drop_cnt", 32'(drop_cnt), 2);
    chk("t4_no_writes", 32'(wr_total - wr0), 0);
    chk("t4_busy", 32'(busy), 0);
    push(10'd319, 10'd239, 12'h123, ok);
    got = 1'b0; seen_addr = '0; seen_data = '0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk); #1;
      if (gpu_write) begin got = 1'b1; seen_addr = gpu_addr; seen_data = gpu_data; end
    end
    chk("t4_inrange_wr", 32'(got), 1);
    chk("t4_addr", 32'(seen_addr), 76799);
    chk("t4_data", 32'(seen_data), 32'h0123);

    // 5: full clear, with a fragment queued mid-clear landing afterwards
    @(negedge clk); clear = 1'b1; clear_color = 12'h00F;
    @(negedge clk); clear = 1'b0; clear_color = 12'hFFF;
    exp_n = 0; seq_err = 0; got = 1'b0;
    for (int c = 0; c < NPIX + 300 && !got; c++) begin
      @(negedge clk);
      if (c == 100) begin frag_valid = 1'b1; frag_x = 10'd10; frag_y = 10'd3; frag_color = 12'hABC; end
      if (c == 101) frag_valid = 1'b0;
      #1;
      if (gpu_write) begin
        if (exp_n < NPIX) begin
          if (gpu_addr !== 18'(exp_n) || gpu_data !== 16'h000F) seq_err++;
          exp_n++;
        end else begin
          got = 1'b1; seen_addr = gpu_addr; seen_data = gpu_data;
        end
      end
    end
    chk("t5_clear_cnt", 32'(exp_n), NPIX);
    chk("t5_clear_err", 32'(seq_err), 0);
    chk("t5_frag_after", 32'(got), 1);
    chk("t5_frag_addr", 32'(seen_addr), 970);
    chk("t5_frag_data", 32'(seen_data), 32'h0ABC);
    @(negedge clk); #1;
    chk("t5_idle", 32'(busy), 0);

    // 6: clear under toggling video, then reset at address 1000
    @(negedge clk); clear = 1'b1; clear_color = 12'h5A5; video_on = 1'b0;
    @(negedge clk); clear = 1'b0;
    exp_n = 0; seq_err = 0;
    for (int c = 0; c < 5000 && exp_n < 1000; c++) begin
      @(negedge clk);
      if (c % 7 == 0) video_on = ~video_on;
      if (c == 50) begin frag_valid = 1'b1; frag_x = 10'd1; frag_y = 10'd1; frag_color = 12'h777; end
      if (c == 51) frag_valid = 1'b0;
      #1;
      if (gpu_write) begin
        if (gpu_addr !== 18'(exp_n) || gpu_data !== 16'h05A5) seq_err++;
        exp_n++;
      end
    end
    chk("t6_reached", 32'(exp_n), 1000);
    chk("t6_seq_err", 32'(seq_err), 0);
    chk("t6_video_viol", 32'(video_viol), 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("t6_rst_write", 32'(gpu_write), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_addr", 32'(gpu_addr), 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0; video_on = 1'b0;
    wr0 = wr_total;
    repeat (20) @(negedge clk);
    #1;
    chk("t6_no_writes", 32'(wr_total - wr0), 0);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_drop_rst", 32'(drop_cnt), 0);
    chk("t6_ready", 32'(frag_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
